n_bit_debounce_synchroniser: RTL and testbench
==============================================

N_BIT_DEBOUNCE_SYNCHRONISER -- requirements
Module: n_bit_debounce_synchroniser

Interface
REQ-001 SHALL have parameter WIDTH, default 1, number of independent channels (>=1).
REQ-002 SHALL have parameter LENGTH, default 2, synchroniser flop stages per channel (>=2).
REQ-003 SHALL have parameter FILTER, default 4, consecutive cycles of stability required before the filtered output changes (>=1).
REQ-004 SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}, value loaded into all per-channel state on reset.
REQ-005 SHALL have port clock  input  1  single clock for all logic.
REQ-006 SHALL have port resetN  input  1  reset, synchronous to clock and active-low.
REQ-007 SHALL have port asyncIn  input  WIDTH  asynchronous channel inputs.
REQ-008 SHALL have port syncOut  output  WIDTH  raw synchronised value (last chain stage).
REQ-009 SHALL have port filtOut  output  WIDTH  debounced value.
REQ-010 SHALL have port rise  output  WIDTH  one-cycle pulse per channel on filtOut 0->1.
REQ-011 SHALL have port fall  output  WIDTH  one-cycle pulse per channel on filtOut 1->0.
REQ-012 SHALL have port anyChange  output  1  OR of all rise and fall bits.

Function
REQ-013 SHALL pass each asyncIn bit through a LENGTH-flop chain; syncOut is the final flop; no combinational path from asyncIn to any output.
REQ-014 SHALL give syncOut a latency of LENGTH clock edges from the first edge sampling a stable new asyncIn value.
REQ-015 SHALL keep one stability counter per channel, width $clog2(FILTER+1), saturating never wraps.
REQ-016 SHALL clear the channel counter on any cycle where syncOut equals filtOut for that channel.
REQ-017 SHALL increment the counter on each cycle where syncOut differs from filtOut and counter < FILTER-1.
REQ-018 SHALL, when syncOut differs from filtOut and counter == FILTER-1, load filtOut <= syncOut and clear the counter on that edge.
REQ-019 SHALL give filtOut a total latency of LENGTH+FILTER edges for a stable input change; FILTER=1 gives one extra cycle over syncOut.
REQ-020 SHALL reject any syncOut excursion shorter than FILTER cycles: filtOut unchanged, no pulse, counter returns to 0.
REQ-021 SHALL assert rise (fall) registered, for exactly one cycle, coincident with the cycle filtOut first shows the new 1 (0).
REQ-022 SHALL never assert rise and fall for the same channel in the same cycle.
REQ-023 SHALL process channels fully independently; simultaneous qualifying changes on several channels produce simultaneous pulses.
REQ-024 SHALL assert anyChange combinationally from registered rise|fall (no extra latency).

Reset
REQ-025 SHALL, on any rising edge with resetN low, load all chain flops, syncOut and filtOut with RESET_VALUE, clear all counters, rise, fall, anyChange.
REQ-026 SHALL override all function rules with reset, including mid-count and mid-pulse; an interrupted count is discarded.
REQ-027 SHALL produce no rise/fall pulse in the first FILTER cycles after reset release if asyncIn equals RESET_VALUE; a differing asyncIn is debounced normally from release.

Verification (WIDTH=4, LENGTH=2, FILTER=3, RESET_VALUE=4'h0, unless stated)
REQ-028 SHALL cover: hold resetN low 2 edges, asyncIn=4'h0 -> syncOut=filtOut=4'h0, rise=fall=0, anyChange=0.
REQ-029 SHALL cover: asyncIn 4'h0->4'h1 held stable -> syncOut=4'h1 after 2 edges, filtOut=4'h1 and rise=4'h1 for one cycle after 5 edges, then rise=0.
REQ-030 SHALL cover: bit0 high for 2 cycles then low -> syncOut bit0 pulses 2 cycles, filtOut stays 4'h0, rise/fall/anyChange stay 0.
REQ-031 SHALL cover: filtOut=4'hF, asyncIn 4'hF->4'h5 -> fall=4'hA one cycle after 5 edges, filtOut=4'h5, anyChange=1 that cycle only.
REQ-032 SHALL cover: resetN pulsed low at counter=2 during a 0->1 change -> filtOut=4'h0, no rise, counter restarts after release and filtOut=4'h1 after LENGTH+FILTER edges from release.
REQ-033 SHALL cover: FILTER=1, asyncIn bit3 toggles every 4 cycles -> filtOut bit3 follows syncOut with 1-cycle delay, alternating rise/fall pulses.

Source files
------------

// File: rtl/n_bit_debounce_synchroniser.sv
// ---------------------------------------------------------------------------
// n_bit_debounce_synchroniser
//
// Brings WIDTH independent asynchronous inputs into the clock domain through
// a LENGTH-flop synchroniser chain. Each synchronised bit is then debounced:
// the filtered output only takes a new value after the synchronised value
// has differed from it for FILTER consecutive cycles. Registered one-cycle
// rise/fall pulses mark each accepted change of the filtered output.
//
// Parameters
//   WIDTH        number of independent channels (>= 1)
//   LENGTH       synchroniser flop stages per channel (>= 2)
//   FILTER       cycles of stable difference needed to change filtOut (>= 1)
//   RESET_VALUE  value loaded into chain flops and filtOut on reset
//
// Ports
//   clock      single clock for all logic
//   resetN     synchronous, active-low reset
//   asyncIn    asynchronous channel inputs
//   syncOut    raw synchronised value (last chain stage)
//   filtOut    debounced value
//   rise       one-cycle pulse per channel on filtOut 0->1
//   fall       one-cycle pulse per channel on filtOut 1->0
//   anyChange  OR of all rise and fall bits
// ---------------------------------------------------------------------------
module n_bit_debounce_synchroniser #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      LENGTH      = 2,
  parameter int unsigned      FILTER      = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut,
  output logic [WIDTH-1:0] filtOut,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             anyChange
);

  localparam int unsigned     CW   = $clog2(FILTER + 1);
  // Terminal count: the FILTER-th consecutive differing cycle loads filtOut.
  localparam logic [CW-1:0]   LAST = CW'(FILTER - 1);

  // Synchroniser chain: stage 0 samples asyncIn, stage LENGTH-1 is syncOut.
  logic [LENGTH-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      chain <= {LENGTH{RESET_VALUE}};
    end else begin
      chain <= {chain[LENGTH-2:0], asyncIn};
    end
  end

  assign syncOut = chain[LENGTH-1];

  // Debounce state per channel.
  logic [WIDTH-1:0][CW-1:0] count_q;
  logic [WIDTH-1:0][CW-1:0] count_d;
  logic [WIDTH-1:0]         filt_d;
  logic [WIDTH-1:0]         rise_d;
  logic [WIDTH-1:0]         fall_d;

  always_comb begin
    filt_d  = filtOut;
    count_d = count_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned ch = 0; ch < WIDTH; ch++) begin
      if (syncOut[ch] == filtOut[ch]) begin
        // Agreement discards any partial count, so short glitches vanish.
        count_d[ch] = '0;
      end else if (count_q[ch] >= LAST) begin
        filt_d[ch]  = syncOut[ch];
        count_d[ch] = '0;
        rise_d[ch]  = syncOut[ch];
        fall_d[ch]  = ~syncOut[ch];
      end else begin
        count_d[ch] = count_q[ch] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      filtOut <= RESET_VALUE;
      count_q <= '0;
      rise    <= '0;
      fall    <= '0;
    end else begin
      filtOut <= filt_d;
      count_q <= count_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // Built from registered pulses only, so it adds no latency and no
  // combinational path from asyncIn.
  assign anyChange = |(rise | fall);

endmodule

// File: tb/tb_n_bit_debounce_synchroniser.sv
// ---------------------------------------------------------------------------
// tb_n_bit_debounce_synchroniser
//
// Directed bench for n_bit_debounce_synchroniser. One instance uses
// WIDTH=4, LENGTH=2, FILTER=3; a second uses FILTER=1. Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, so the
// value seen after k ticks reflects k clock edges.
// ---------------------------------------------------------------------------
module tb_n_bit_debounce_synchroniser;

  logic       clock;
  logic       reset_n;
  logic [3:0] async_in;
  logic [3:0] sync_out, filt_out, rise, fall;
  logic       any_change;

  logic       reset_n1;
  logic [3:0] async_in1;
  logic [3:0] sync_out1, filt_out1, rise1, fall1;
  logic       any_change1;

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;

  n_bit_debounce_synchroniser #(
    .WIDTH(4), .LENGTH(2), .FILTER(3), .RESET_VALUE(4'h0)
  ) dut (
    .clock(clock), .resetN(reset_n), .asyncIn(async_in),
    .syncOut(sync_out), .filtOut(filt_out), .rise(rise), .fall(fall),
    .anyChange(any_change)
  );

  n_bit_debounce_synchroniser #(
    .WIDTH(4), .LENGTH(2), .FILTER(1), .RESET_VALUE(4'h0)
  ) dut1 (
    .clock(clock), .resetN(reset_n1), .asyncIn(async_in1),
    .syncOut(sync_out1), .filtOut(filt_out1), .rise(rise1), .fall(fall1),
    .anyChange(any_change1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] s,
                           input logic [3:0] f, input logic [3:0] r,
                           input logic [3:0] fl, input logic a);
    check({tag, ".sync"}, 32'(sync_out), 32'(s));
    check({tag, ".filt"}, 32'(filt_out), 32'(f));
    check({tag, ".rise"}, 32'(rise), 32'(r));
    check({tag, ".fall"}, 32'(fall), 32'(fl));
    check({tag, ".any"}, 32'(any_change), 32'(a));
  endtask

  task automatic reset_main(input logic [3:0] value);
    reset_n  = 1'b0;
    async_in = value;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Expected syncOut after each tick for a two-cycle bit0 glitch.
  logic [3:0] glitch_sync [6] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};

  initial begin
    reset_n   = 1'b0;
    async_in  = 4'h0;
    reset_n1  = 1'b0;
    async_in1 = 4'h0;

    // Reset state.
    tick();
    tick();
    check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Release with input equal to reset value: no pulses.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("quiet", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // Stable 0->1 on bit0: syncOut after 2 edges, filtOut/rise after 5.
    async_in = 4'h1;
    tick(); check_all("up.e1", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(); check_all("up.e2", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(); check_all("up.e3", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(); check_all("up.e4", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(); check_all("up.e5", 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
    tick(); check_all("up.e6", 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);

    // Two-cycle glitch on bit0 is rejected.
    reset_main(4'h0);
    for (int i = 0; i < 3; i++) tick();
    async_in = 4'h1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) async_in = 4'h0;
      check_all("glitch", glitch_sync[i], 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // Reach filtOut=F, then drop bits 1 and 3: fall=A.
    async_in = 4'hF;
    for (int i = 0; i < 4; i++) tick();
    tick(); check_all("allup", 4'hF, 4'hF, 4'hF, 4'h0, 1'b1);
    tick(); check_all("allup.after", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
    async_in = 4'h5;
    tick(); check_all("down.e1", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
    tick(); check_all("down.e2", 4'h5, 4'hF, 4'h0, 4'h0, 1'b0);
    tick(); check_all("down.e3", 4'h5, 4'hF, 4'h0, 4'h0, 1'b0);
    tick(); check_all("down.e4", 4'h5, 4'hF, 4'h0, 4'h0, 1'b0);
    tick(); check_all("down.e5", 4'h5, 4'h5, 4'h0, 4'hA, 1'b1);
    tick(); check_all("down.e6", 4'h5, 4'h5, 4'h0, 4'h0, 1'b0);

    // Reset lands on the edge that would have loaded filtOut.
    reset_main(4'h0);
    for (int i = 0; i < 3; i++) tick();
    async_in = 4'h1;
    for (int i = 0; i < 4; i++) tick();
    check_all("midcount", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    reset_n = 1'b0;
    tick(); check_all("midreset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    reset_n = 1'b1;
    tick(); check_all("rel.e1", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(); check_all("rel.e2", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(); check_all("rel.e3", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(); check_all("rel.e4", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(); check_all("rel.e5", 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
    tick(); check_all("rel.e6", 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);

    // FILTER=1: bit3 toggles every 4 cycles; filtOut trails syncOut by one.
    reset_n1 = 1'b1;
    tick();
    tick();
    for (int p = 0; p < 4; p++) begin
      logic [3:0] new_v, old_v;
      new_v = (p % 2 == 0) ? 4'h8 : 4'h0;
      old_v = new_v ^ 4'h8;
      async_in1 = new_v;
      for (int t = 1; t <= 4; t++) begin
        tick();
        check("f1.sync", 32'(sync_out1), 32'((t >= 2) ? new_v : old_v));
        check("f1.filt", 32'(filt_out1), 32'((t >= 3) ? new_v : old_v));
        check("f1.rise", 32'(rise1), 32'((t == 3 && new_v == 4'h8) ? 4'h8 : 4'h0));
        check("f1.fall", 32'(fall1), 32'((t == 3 && new_v == 4'h0) ? 4'h8 : 4'h0));
        check("f1.any", 32'(any_change1), 32'(t == 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
